// File: rtl/psg_pkg.sv
// psg_pkg: shared constants for the SN76489-style PSG write-port logic.
//   - Register indices: {channel[1:0], type}, where type 1 = attenuation.
//   - Field positions inside a CPU write byte.
//   - Reset values for the tone and attenuation registers.
package psg_pkg;

    // Register indices, laid out as {channel, type}
    localparam logic [2:0] TONE0_F    = 3'd0;
    localparam logic [2:0] TONE0_A    = 3'd1;
    localparam logic [2:0] TONE1_F    = 3'd2;
    localparam logic [2:0] TONE1_A    = 3'd3;
    localparam logic [2:0] TONE2_F    = 3'd4;
    localparam logic [2:0] TONE2_A    = 3'd5;
    localparam logic [2:0] NOISE_CTRL = 3'd6;
    localparam logic [2:0] NOISE_A    = 3'd7;

    // Write-byte field positions
    localparam int LATCH_BIT = 7;
    localparam int CHAN_MSB  = 6;
    localparam int CHAN_LSB  = 5;
    localparam int TYPE_BIT  = 4;

    // Reset values
    localparam logic [3:0] ATTEN_OFF  = 4'hF;
    localparam logic [9:0] TONE_RESET = 10'd0;

    // Register index named by a latch byte
    function automatic logic [2:0] latch_index(input logic [7:0] byte_in);
        return {byte_in[CHAN_MSB:CHAN_LSB], byte_in[TYPE_BIT]};
    endfunction

endpackage

// File: rtl/psg_prescaler.sv
// psg_prescaler: free-running master-clock divider that produces a one-cycle
// enable pulse every CLK_DIV cycles.
//   clk        in   master clock
//   reset      in   synchronous, active-high reset
//   gen_enable out  high for one cycle when the count is CLK_DIV-1
module psg_prescaler #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    output logic gen_enable
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          gen_enable_reg;

    always_comb begin
        count_next = (count_reg == LAST) ? '0 : count_reg + CW'(1);
    end

    // The pulse is registered alongside the count so it is low during and
    // right after reset, even when CLK_DIV = 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg      <= '0;
            gen_enable_reg <= 1'b0;
        end else begin
            count_reg      <= count_next;
            gen_enable_reg <= (count_next == LAST);
        end
    end

    assign gen_enable = gen_enable_reg;

endmodule

// File: rtl/psg_control.sv
// psg_control: CPU write-port controller for an SN76489-style PSG.
// Decodes latch/data bytes into tone compare values, attenuations and noise
// control, models the READY busy window, and generates the generator enable.
//   clk            in   master clock
//   reset          in   synchronous, active-high reset
//   data[7:0]      in   CPU write byte
//   we             in   write strobe, one byte per cycle
//   ready          out  high = next write will be accepted
//   tone0..2_compare out 10-bit tone period registers
//   atten0..3      out  4-bit attenuations (atten3 = noise), F = off
//   noise_ctrl     out  [2] white/periodic, [1:0] rate
//   noise_reset    out  one-cycle pulse on every noise control write
//   gen_enable     out  one-cycle prescaler pulse
//   dropped        out  sticky: a write arrived while busy
module psg_control
    import psg_pkg::*;
#(
    parameter int CLK_DIV     = 16,
    parameter int WAIT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       we,
    output logic       ready,
    output logic [9:0] tone0_compare,
    output logic [9:0] tone1_compare,
    output logic [9:0] tone2_compare,
    output logic [3:0] atten0,
    output logic [3:0] atten1,
    output logic [3:0] atten2,
    output logic [3:0] atten3,
    output logic [2:0] noise_ctrl,
    output logic       noise_reset,
    output logic       gen_enable,
    output logic       dropped
);

    localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [WW-1:0] wait_reg;
    logic [2:0]    latch_reg;
    logic [2:0]    noise_ctrl_reg;
    logic          noise_reset_reg;
    logic          dropped_reg;

    logic          accept;
    logic          is_latch;
    logic [2:0]    target;

    assign ready    = (wait_reg == '0);
    assign accept   = we && ready;
    assign is_latch = data[LATCH_BIT];
    // A latch byte names its own target; a data byte reuses the last latch.
    assign target   = is_latch ? latch_index(data) : latch_reg;

    // Busy window, latched target and sticky drop flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_reg    <= '0;
            latch_reg   <= TONE0_F;
            dropped_reg <= 1'b0;
        end else begin
            if (accept && (WAIT_CYCLES > 0)) begin
                wait_reg <= WW'(WAIT_CYCLES);
            end else if (wait_reg != '0) begin
                wait_reg <= wait_reg - WW'(1);
            end
            if (accept && is_latch) begin
                latch_reg <= latch_index(data);
            end
            if (we && !ready) begin
                dropped_reg <= 1'b1;
            end
        end
    end

    // Tone period registers: latch bytes fill [3:0], data bytes fill [9:4].
    for (genvar gi = 0; gi < 3; gi++) begin : gen_tone
        localparam logic [2:0] IDX = 3'(2 * gi);
        logic [9:0] tone_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                tone_reg <= TONE_RESET;
            end else if (accept && (target == IDX)) begin
                if (is_latch) begin
                    tone_reg[3:0] <= data[3:0];
                end else begin
                    tone_reg[9:4] <= data[5:0];
                end
            end
        end
    end

    // Attenuation registers: both byte kinds write the full nibble.
    for (genvar gi = 0; gi < 4; gi++) begin : gen_atten
        localparam logic [2:0] IDX = 3'(2 * gi + 1);
        logic [3:0] atten_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                atten_reg <= ATTEN_OFF;
            end else if (accept && (target == IDX)) begin
                atten_reg <= data[3:0];
            end
        end
    end

    // Noise control; the reset pulse fires on every write, changed or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            noise_ctrl_reg  <= 3'd0;
            noise_reset_reg <= 1'b0;
        end else begin
            noise_reset_reg <= 1'b0;
            if (accept && (target == NOISE_CTRL)) begin
                noise_ctrl_reg  <= data[2:0];
                noise_reset_reg <= 1'b1;
            end
        end
    end

    psg_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .gen_enable (gen_enable)
    );

    assign tone0_compare = gen_tone[0].tone_reg;
    assign tone1_compare = gen_tone[1].tone_reg;
    assign tone2_compare = gen_tone[2].tone_reg;
    assign atten0        = gen_atten[0].atten_reg;
    assign atten1        = gen_atten[1].atten_reg;
    assign atten2        = gen_atten[2].atten_reg;
    assign atten3        = gen_atten[3].atten_reg;
    assign noise_ctrl    = noise_ctrl_reg;
    assign noise_reset   = noise_reset_reg;
    assign dropped       = dropped_reg;

endmodule

// File: tb/tb_psg_control.sv
// tb_psg_control: directed plus randomized bench for psg_control. A
// behavioural model tracks what the registers must hold after every clock
// edge; a negedge process compares every output against it, and a few
// hand-computed literal checks pin the model itself.
module tb_psg_control;

    localparam int CLK_DIV     = 16;
    localparam int WAIT_CYCLES = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data = 8'h00;
    logic       we = 1'b0;
    logic       ready;
    logic [9:0] tone0_compare, tone1_compare, tone2_compare;
    logic [3:0] atten0, atten1, atten2, atten3;
    logic [2:0] noise_ctrl;
    logic       noise_reset, gen_enable, dropped;

    psg_control #(
        .CLK_DIV(CLK_DIV),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data          (data),
        .we            (we),
        .ready         (ready),
        .tone0_compare (tone0_compare),
        .tone1_compare (tone1_compare),
        .tone2_compare (tone2_compare),
        .atten0        (atten0),
        .atten1        (atten1),
        .atten2        (atten2),
        .atten3        (atten3),
        .noise_ctrl    (noise_ctrl),
        .noise_reset   (noise_reset),
        .gen_enable    (gen_enable),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model state: values the outputs must show after the latest edge.
    bit valid = 0;
    int t = 0;            // edges applied so far
    int ready_at = 0;     // first edge index at which writes are accepted again
    int n_run = 0;        // edges since reset released
    int m_tone [3];
    int m_atten [4];
    int m_noise = 0;
    int m_chan = 0;
    int m_type = 0;
    bit m_pulse = 0;
    bit m_dropped = 0;

    function automatic bit m_ready();
        return t >= ready_at;
    endfunction

    function automatic bit m_gen();
        return (n_run > 0) && ((n_run % CLK_DIV) == CLK_DIV - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit r, input bit w, input logic [7:0] d);
        bit was_ready;
        int ch, ty;
        was_ready = m_ready();
        t++;
        m_pulse = 0;
        if (r) begin
            for (int i = 0; i < 3; i++) m_tone[i] = 0;
            for (int i = 0; i < 4; i++) m_atten[i] = 15;
            m_noise = 0;
            m_chan = 0;
            m_type = 0;
            m_dropped = 0;
            ready_at = t;
            n_run = 0;
            return;
        end
        n_run++;
        if (!w) return;
        if (!was_ready) begin
            m_dropped = 1;
            return;
        end
        ready_at = t + WAIT_CYCLES;
        if (d[7]) begin
            m_chan = int'(d[6:5]);
            m_type = int'(d[4]);
        end
        ch = m_chan;
        ty = m_type;
        if (ty == 1) begin
            m_atten[ch] = int'(d[3:0]);
        end else if (ch == 3) begin
            m_noise = int'(d[2:0]);
            m_pulse = 1;
        end else if (d[7]) begin
            m_tone[ch] = (m_tone[ch] & 'h3F0) | int'(d[3:0]);
        end else begin
            m_tone[ch] = (m_tone[ch] & 'h00F) | (int'(d[5:0]) << 4);
        end
    endtask

    // Drive one edge's inputs, update the model, return just after the edge.
    task automatic step(input bit r, input bit w, input logic [7:0] d);
        @(negedge clk);
        #1;
        reset = r;
        we    = w;
        data  = d;
        model_step(r, w, d);
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 8'h00);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (valid) begin
            chk("ready", int'(ready), int'(m_ready()));
            chk("tone0", int'(tone0_compare), m_tone[0]);
            chk("tone1", int'(tone1_compare), m_tone[1]);
            chk("tone2", int'(tone2_compare), m_tone[2]);
            chk("atten0", int'(atten0), m_atten[0]);
            chk("atten1", int'(atten1), m_atten[1]);
            chk("atten2", int'(atten2), m_atten[2]);
            chk("atten3", int'(atten3), m_atten[3]);
            chk("noise_ctrl", int'(noise_ctrl), m_noise);
            chk("noise_reset", int'(noise_reset), int'(m_pulse));
            chk("gen_enable", int'(gen_enable), int'(m_gen()));
            chk("dropped", int'(dropped), int'(m_dropped));
        end
    end

    initial begin
        logic [7:0] rd;
        bit rw, rr;

        // Reset state
        step(1, 0, 8'h00);
        valid = 1;
        step(1, 0, 8'h00);
        chk("lit_rst_atten0", int'(atten0), 'hF);
        chk("lit_rst_atten3", int'(atten3), 'hF);
        chk("lit_rst_tone0", int'(tone0_compare), 0);
        chk("lit_rst_ready", int'(ready), 1);
        chk("lit_rst_gen", int'(gen_enable), 0);
        chk("lit_rst_dropped", int'(dropped), 0);

        // Prescaler: high on the 16th cycle after release, then every 16
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 8'h00);
            chk("lit_gen", int'(gen_enable), ((i == 15) || (i == 31)) ? 1 : 0);
        end

        // Tone0 = 0FE via latch 8E + data 0F
        step(0, 1, 8'h8E);
        chk("lit_busy", int'(ready), 0);
        idle(WAIT_CYCLES);
        step(0, 1, 8'h0F);
        chk("lit_tone0_0fe", int'(tone0_compare), 'h0FE);
        chk("lit_no_nrst", int'(noise_reset), 0);
        idle(WAIT_CYCLES);

        // Attenuation ch2
        step(0, 1, 8'hD5);
        chk("lit_atten2_5", int'(atten2), 5);
        idle(WAIT_CYCLES);
        step(0, 1, 8'h0A);
        chk("lit_atten2_a", int'(atten2), 'hA);
        idle(WAIT_CYCLES);
        step(0, 1, 8'h03);
        chk("lit_atten2_3", int'(atten2), 3);
        chk("lit_tone0_kept", int'(tone0_compare), 'h0FE);
        idle(WAIT_CYCLES);

        // Noise control, pulse on each write even if unchanged
        step(0, 1, 8'hE4);
        chk("lit_noise_4", int'(noise_ctrl), 4);
        chk("lit_nrst_1", int'(noise_reset), 1);
        step(0, 0, 8'h00);
        chk("lit_nrst_0", int'(noise_reset), 0);
        idle(WAIT_CYCLES - 1);
        step(0, 1, 8'hE4);
        chk("lit_noise_4b", int'(noise_ctrl), 4);
        chk("lit_nrst_1b", int'(noise_reset), 1);
        idle(WAIT_CYCLES);

        // Write during busy window is dropped
        step(0, 1, 8'h81);
        chk("lit_tone0_0f1", int'(tone0_compare), 'h0F1);
        idle(4);
        step(0, 1, 8'h8F);
        chk("lit_drop_tone0", int'(tone0_compare), 'h0F1);
        chk("lit_dropped", int'(dropped), 1);
        idle(26);
        chk("lit_ready_low32", int'(ready), 0);
        step(0, 0, 8'h00);
        chk("lit_ready_back", int'(ready), 1);

        // Reset in the middle of a latch sequence and busy window
        step(0, 1, 8'hA0);
        chk("lit_busy_a0", int'(ready), 0);
        step(1, 0, 8'h00);
        chk("lit_ready_rst", int'(ready), 1);
        chk("lit_dropped_rst", int'(dropped), 0);
        step(0, 1, 8'h3F);
        chk("lit_tone0_3f0", int'(tone0_compare), 'h3F0);
        chk("lit_tone1_0", int'(tone1_compare), 0);
        chk("lit_tone2_0", int'(tone2_compare), 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 599) == 0);
            rw = ($urandom_range(0, 2) == 0);
            rd = 8'($urandom);
            step(rr, rw, rd);
        end

        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psg_control.md
Name: psg_control

Overview:
- Write-port controller for the SN76489-style PSG.
- Decodes the byte-wide CPU write protocol (latch/data bytes) into the three 10-bit tone compare values, four 4-bit attenuations and the 3-bit noise control that feed the tone/noise generators.
- Generates the shared master-clock prescaler enable for those generators.
- Models the chip READY line: a busy window follows each accepted write.

Parameters:
- CLK_DIV, 16, master clocks per generator enable pulse (>=1; 1 = enable every cycle).
- WAIT_CYCLES, 32, cycles READY stays low after an accepted write (0 = always ready).

Ports:
- clk  in  1  master clock
- reset  in  1  synchronous, active-high reset
- data  in  8  CPU write byte
- we  in  1  write strobe; one byte per cycle when high
- ready  out  1  high = next write will be accepted
- tone0_compare, tone1_compare, tone2_compare  out  10 each  tone period registers
- atten0, atten1, atten2, atten3  out  4 each  attenuation (ch3 = noise); 4'hF = off
- noise_ctrl  out  3  [2] = white/periodic, [1:0] = rate
- noise_reset  out  1  one-cycle pulse on any noise_ctrl write
- gen_enable  out  1  one-cycle prescaler pulse
- dropped  out  1  sticky: a write arrived while ready=0

Behaviour:
- Reset (sync, active-high). All outputs take these values on the first clk edge with reset=1:
  - tone*_compare = 0, atten* = 4'hF, noise_ctrl = 0.
  - noise_reset = 0, gen_enable = 0, dropped = 0, ready = 1.
  - Latched register = tone0 frequency; prescaler count = 0; wait count = 0.
- A write is accepted when we=1 and ready=1 at the clk edge. Register outputs reflect it on the following cycle (1-cycle latency).
- Latch byte (data[7]=1):
  - Latches target = {data[6:5] channel, data[4] type}; type 1 = attenuation, 0 = frequency/noise.
  - Writes data[3:0] immediately:
    - tone frequency: compare[3:0]
    - attenuation: atten
    - noise (ch3, type 0): noise_ctrl <= data[2:0]
- Data byte (data[7]=0):
  - Target = last latched register.
  - Tone frequency: compare[9:4] <= data[5:0].
  - Attenuation: atten <= data[3:0].
  - Noise: noise_ctrl <= data[2:0].
  - data[6] ignored.
- noise_reset:
  - Pulses high for exactly one cycle, coincident with the noise_ctrl update, on every accepted write targeting noise control.
  - Pulses even if the value is unchanged.
- Attenuation writes and tone writes never pulse noise_reset.
- Compare value 0 is stored as-is; interpreting 0 as period 1024 is the generator's job.
- Ready / wait window:
  - After an accepted write with WAIT_CYCLES>0, ready=0 for exactly WAIT_CYCLES cycles starting the next cycle, then returns to 1.
  - Writes with ready=0 are ignored (no register change, no pulse) and set dropped=1 until reset.
- Prescaler:
  - Counter 0..CLK_DIV-1, free-running from reset.
  - gen_enable=1 in the cycle the count equals CLK_DIV-1, then it wraps to 0.
  - First pulse occurs CLK_DIV cycles after reset deasserts.
  - Unaffected by writes.
- Reset mid-wait or mid-latch sequence:
  - Aborts the sequence.
  - Wait count cleared; a data byte after reset targets tone0 frequency.

Decomposition:
- psg_pkg holds:
  - Register index constants: TONE0_F, TONE0_A ... NOISE_CTRL, NOISE_A.
  - Field positions: LATCH_BIT = 7, CHAN_MSB/LSB, TYPE_BIT.
  - Reset constants: ATTEN_OFF = 4'hF, TONE_RESET = 10'd0.
- Sub-module psg_prescaler (counter + gen_enable), reused by any future clock-enable consumer.
- Decoder, wait counter and register bank stay in psg_control.

Test Plan:
- Reset release, no writes -> atten* = F, compares = 0, ready = 1; gen_enable first high on cycle 16, then every 16 cycles.
- Write 8'h8E then 8'h0F (ready permitting) -> tone0_compare = 10'h0FE; no noise_reset pulse.
- Write 8'hD5 -> atten2 = 5. Following data byte 8'h0A -> atten2 = A, latch still ch2 attenuation.
- Write 8'hE4 -> noise_ctrl = 3'b100, noise_reset high exactly one cycle. Repeat 8'hE4 -> pulse again, value unchanged.
- Write, then second write 5 cycles later (WAIT_CYCLES=32) -> second ignored, dropped = 1; ready returns high 32 cycles after first accept.
- Latch 8'hA0 then reset, then data 8'h3F -> tone0_compare = 10'h3F0, tone2_compare = 0.
